// File: rtl/temp_avg_pkg.sv
// temp_avg_pkg
// Shared definitions for the temperature FIFO consumer and the header detector.
// Contents: default parameter values, the sample-group header bytes, and the
// consumer FSM state type.
package temp_avg_pkg;

  localparam int DEF_SAMPLE_SHIFT = 2;
  localparam int DEF_ADDR_W       = 4;

  // Header bytes that frame a 4-byte sample group in the FIFO stream
  localparam logic [7:0] HDR_BYTE0 = 8'hA5;
  localparam logic [7:0] HDR_BYTE1 = 8'hC3;

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_AVG     = 3'd3,
    S_WRITE   = 3'd4
  } state_t;

endpackage

// File: rtl/temp_avg_addr_gen.sv
// temp_avg_addr_gen
// Wrapping result-RAM write address counter with a sticky wrap flag.
// Ports:
//   clk_50   in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear of address and wrap flag (wins over inc)
//   inc      in   advance address by one (modulo 2**ADDR_W)
//   addr     out  current write address
//   wrapped  out  sticky; set when addr rolls over from max to 0
module temp_avg_addr_gen
  import temp_avg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              wrapped
);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else if (clr) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else if (inc) begin
      addr <= addr + 1'b1;
      if (addr == '1) wrapped <= 1'b1;
    end
  end

endmodule

// File: rtl/temp_avg_ctrl.sv
// temp_avg_ctrl
// Pops bytes from the temperature FIFO, accumulates groups of 2**SAMPLE_SHIFT
// bytes and writes each group average to the result RAM at a wrapping address.
// Build option: TEMP_AVG_ROUND_EN selects round-half-up averaging (saturated
// to 8'hFF) instead of the default truncating shift.
// Ports:
//   clk_50       in   system clock (50 MHz)
//   reset_n      in   asynchronous active-low reset
//   clr          in   synchronous clear of group, address and flags
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid the cycle after rd_fifo
//   rd_fifo      out  FIFO pop strobe, one cycle per byte
//   ram_addr     out  RAM write address
//   ram_wr_data  out  RAM write data (group average)
//   ram_wr       out  RAM write strobe, one cycle per group
//   group_done   out  one-cycle pulse coincident with ram_wr
//   wrapped      out  sticky; set when ram_addr wraps from max to 0
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_WAIT    | idle, waiting for the FIFO to hold data
// S_READ    | pop strobe to the FIFO
// S_CAPTURE | add the popped byte to the accumulator, count it
// S_AVG     | register the group average
// S_WRITE   | RAM write strobe; clear group, advance address
module temp_avg_ctrl
  import temp_avg_pkg::*;
#(
  parameter int SAMPLE_SHIFT = DEF_SAMPLE_SHIFT,
  parameter int ADDR_W       = DEF_ADDR_W
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              fifo_empty,
  input  logic [7:0]        fifo_dout,
  output logic              rd_fifo,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wr_data,
  output logic              ram_wr,
  output logic              group_done,
  output logic              wrapped
);

  // Wide enough that 2**SAMPLE_SHIFT full-scale bytes never overflow
  localparam int ACC_W = 8 + SAMPLE_SHIFT;

  state_t                  state, state_nx;
  logic [ACC_W-1:0]        acc;
  logic [SAMPLE_SHIFT-1:0] byte_cnt;
  logic [7:0]              avg_val;

`ifdef TEMP_AVG_ROUND_EN
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(2 ** (SAMPLE_SHIFT - 1));
  logic [ACC_W:0] rnd_sum;

  // The top bit of the widened sum is the only way the shifted result can
  // exceed 8 bits; saturate on it.
  always_comb begin
    rnd_sum = {1'b0, acc} + HALF;
    avg_val = rnd_sum[ACC_W] ? 8'hFF : rnd_sum[ACC_W-1:SAMPLE_SHIFT];
  end
`else
  assign avg_val = acc[ACC_W-1:SAMPLE_SHIFT];
`endif

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n)  state <= S_WAIT;
    else if (clr)  state <= S_WAIT;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:    if (!fifo_empty) state_nx = S_READ;
      S_READ:    state_nx = S_CAPTURE;
      S_CAPTURE: begin
        if (byte_cnt == '1)   state_nx = S_AVG;
        else if (!fifo_empty) state_nx = S_READ;
        else                  state_nx = S_WAIT;
      end
      S_AVG:     state_nx = S_WRITE;
      S_WRITE:   state_nx = S_WAIT;
      default:   state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      acc         <= '0;
      byte_cnt    <= '0;
      ram_wr_data <= '0;
    end else if (clr) begin
      acc         <= '0;
      byte_cnt    <= '0;
      ram_wr_data <= '0;
    end else begin
      case (state)
        S_CAPTURE: begin
          acc      <= acc + ACC_W'(fifo_dout);
          byte_cnt <= byte_cnt + 1'b1;
        end
        S_AVG:     ram_wr_data <= avg_val;
        S_WRITE: begin
          acc      <= '0;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rd_fifo    = (state == S_READ);
  assign ram_wr     = (state == S_WRITE);
  assign group_done = ram_wr;

  temp_avg_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (ram_wr),
    .addr    (ram_addr),
    .wrapped (wrapped)
  );

endmodule

// File: tb/tb_temp_avg_ctrl.sv
// tb_temp_avg_ctrl
// Directed and randomized checks of temp_avg_ctrl against a FIFO model and a
// group-average reference. Built with a 4-entry RAM so address wrap is reached.
module tb_temp_avg_ctrl;
  import temp_avg_pkg::*;

  localparam int SS    = 2;
  localparam int AW    = 2;
  localparam int GROUP = 1 << SS;
  localparam int DEPTH = 1 << AW;

  logic          clk_50 = 1'b0;
  logic          reset_n;
  logic          clr;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
  logic          rd_fifo;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wr_data;
  logic          ram_wr;
  logic          group_done;
  logic          wrapped;

  temp_avg_ctrl #(.SAMPLE_SHIFT(SS), .ADDR_W(AW)) dut (
    .clk_50      (clk_50),
    .reset_n     (reset_n),
    .clr         (clr),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .rd_fifo     (rd_fifo),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr      (ram_wr),
    .group_done  (group_done),
    .wrapped     (wrapped)
  );

  always #10 clk_50 = ~clk_50;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] fifo_q[$];
  bit         hold      = 1'b0;
  int         underflow = 0;

  int ncyc   = 0;
  int gd_bad = 0;
  int rd_cyc_q[$];
  int wr_cyc_q[$];
  int wr_addr_q[$];
  int wr_data_q[$];

  int exp_addr    = 0;
  bit exp_wrapped = 1'b0;

  // FIFO model: pop on a sampled rd_fifo, data valid the following cycle,
  // empty flag refreshed shortly after each edge.
  initial begin
    fifo_dout  = 8'h00;
    fifo_empty = 1'b1;
    forever begin
      @(posedge clk_50);
      if (rd_fifo === 1'b1) begin
        if (fifo_q.size() == 0) underflow++;
        else fifo_dout <= fifo_q.pop_front();
      end
      #1 fifo_empty = hold || (fifo_q.size() == 0);
    end
  end

  // Bus monitor
  initial begin
    forever begin
      @(negedge clk_50);
      ncyc++;
      if (rd_fifo === 1'b1) rd_cyc_q.push_back(ncyc);
      if (ram_wr === 1'b1) begin
        wr_cyc_q.push_back(ncyc);
        wr_addr_q.push_back(int'(ram_addr));
        wr_data_q.push_back(int'(ram_wr_data));
      end
      if (ram_wr !== group_done) gd_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk_50);
      #2;
    end
  endtask

  task automatic push(input int b);
    logic [7:0] v;
    v = b[7:0];
    fifo_q.push_back(v);
  endtask

  function automatic int exp_avg(input int sum);
    int r;
`ifdef TEMP_AVG_ROUND_EN
    r = (sum + GROUP / 2) / GROUP;
    if (r > 255) r = 255;
`else
    r = sum / GROUP;
`endif
    return r;
  endfunction

  task automatic wait_writes(input int n);
    for (int i = 0; i < 300 && wr_addr_q.size() < n; i++) tick();
    chk("write_timeout", wr_addr_q.size(), n);
  endtask

  task automatic wait_reads(input int n);
    for (int i = 0; i < 300 && rd_cyc_q.size() < n; i++) tick();
    chk("read_timeout", rd_cyc_q.size(), n);
  endtask

  // Waits for write number idx, checks it against the model and advances it.
  task automatic check_write(input string tag, input int idx, input int sum);
    wait_writes(idx + 1);
    if (wr_addr_q.size() > idx) begin
      chk({tag, "_addr"}, wr_addr_q[idx], exp_addr);
      chk({tag, "_data"}, wr_data_q[idx], exp_avg(sum));
    end
    if (exp_addr == DEPTH - 1) exp_wrapped = 1'b1;
    exp_addr = (exp_addr + 1) % DEPTH;
    tick();
    chk({tag, "_wrapped"}, wrapped, exp_wrapped);
    chk({tag, "_next_addr"}, ram_addr, exp_addr);
  endtask

  task automatic run_group(input string tag, input int b0, input int b1, input int b2, input int b3);
    int idx;
    idx = wr_addr_q.size();
    push(b0); push(b1); push(b2); push(b3);
    check_write(tag, idx, b0 + b1 + b2 + b3);
  endtask

  initial begin
    int r0, n0, sum, split;
    int b[GROUP];

    reset_n = 1'b0;
    clr     = 1'b0;
    tick(3);
    chk("rst_rd_fifo", rd_fifo, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_group_done", group_done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wr_data", ram_wr_data, 0);
    chk("rst_wrapped", wrapped, 0);
    reset_n = 1'b1;
    tick(2);

    // Back-to-back group: pop every 2 cycles, write 3 cycles after last pop
    r0 = rd_cyc_q.size();
    run_group("g10_40", 10, 20, 30, 40);
    chk("rd_count", rd_cyc_q.size(), r0 + 4);
    for (int i = 1; i < 4; i++) chk("rd_spacing", rd_cyc_q[r0 + i] - rd_cyc_q[r0 + i - 1], 2);
    chk("wr_latency", wr_cyc_q[0] - rd_cyc_q[r0 + 3], 3);

    run_group("g1122", 1, 1, 2, 2);
    run_group("g255", 255, 255, 255, 255);

    // Partial group, then FIFO held empty with data waiting
    r0 = rd_cyc_q.size();
    n0 = wr_addr_q.size();
    push(10); push(20);
    wait_reads(r0 + 2);
    tick(3);
    chk("partial_acc", dut.acc, 30);
    hold = 1'b1;
    push(30); push(40);
    tick(10);
    chk("hold_no_rd", rd_cyc_q.size(), r0 + 2);
    chk("hold_acc", dut.acc, 30);
    chk("hold_no_wr", wr_addr_q.size(), n0);
    hold = 1'b0;
    check_write("resume", n0, 100);

    // Wrap: clear, then five groups of 0x40
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_addr    = 0;
    exp_wrapped = 1'b0;
    chk("clr_addr", ram_addr, 0);
    chk("clr_wrapped", wrapped, 0);
    for (int g = 0; g < 5; g++) run_group("wrap", 8'h40, 8'h40, 8'h40, 8'h40);

    // Reset after 3 of 4 bytes
    r0 = rd_cyc_q.size();
    n0 = wr_addr_q.size();
    push(7); push(8); push(9);
    wait_reads(r0 + 3);
    tick(2);
    reset_n = 1'b0;
    tick();
    chk("rst_mid_addr", ram_addr, 0);
    chk("rst_mid_wrapped", wrapped, 0);
    chk("rst_mid_acc", dut.acc, 0);
    reset_n = 1'b1;
    exp_addr    = 0;
    exp_wrapped = 1'b0;
    tick(10);
    chk("rst_mid_no_wr", wr_addr_q.size(), n0);
    run_group("after_rst", 4, 4, 4, 4);

    // clr while averaging
    r0 = rd_cyc_q.size();
    n0 = wr_addr_q.size();
    push(50); push(60); push(70); push(80);
    wait_reads(r0 + 4);
    tick(2);
    chk("in_avg", dut.state, S_AVG);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_avg_ram_wr", ram_wr, 0);
    chk("clr_avg_addr", ram_addr, 0);
    chk("clr_avg_wrapped", wrapped, 0);
    chk("clr_avg_state", dut.state, S_WAIT);
    exp_addr    = 0;
    exp_wrapped = 1'b0;
    tick(10);
    chk("clr_avg_no_wr", wr_addr_q.size(), n0);

    // Random groups, sometimes delivered in two bursts
    for (int g = 0; g < 24; g++) begin
      n0    = wr_addr_q.size();
      sum   = 0;
      split = $urandom_range(GROUP, 1);
      for (int i = 0; i < GROUP; i++) begin
        b[i] = (g % 5 == 0) ? 255 - $urandom_range(3, 0) : $urandom_range(255, 0);
        sum += b[i];
      end
      for (int i = 0; i < split; i++) push(b[i]);
      tick($urandom_range(6, 0));
      for (int i = split; i < GROUP; i++) push(b[i]);
      check_write("rand", n0, sum);
    end

    chk("group_done_eq_ram_wr", gd_bad, 0);
    chk("fifo_underflow", underflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
